btn_debounce: RTL
=================

BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 Parameter DEBOUNCE, default 4: consecutive stable sample-enabled cycles required to accept a level change; legal range 2..65535.
REQ-002 Parameter INIT_LEVEL, default 0: debounced level after reset.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 en  input  1  sample enable; the FSM and counter advance only in cycles with en=1.
REQ-006 btn_in  input  1  raw asynchronous button or contact input.
REQ-007 btn_level  output  1  debounced level, registered; feeds the downstream FSM "in" input.
REQ-008 btn_rise  output  1  one-clk pulse on an accepted 0->1 change, registered.
REQ-009 btn_fall  output  1  one-clk pulse on an accepted 1->0 change, registered.

Function
REQ-010 btn_in shall pass through a 2-flop synchronizer clocked every cycle, independent of en, to give sync_q.
REQ-011 The FSM shall have exactly four states: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
REQ-012 In STABLE_LO with en=1 and sync_q=1, the FSM shall go to WAIT_HI with cnt=0; otherwise it holds.
REQ-013 In WAIT_HI with en=1:
  - sync_q=0: return to STABLE_LO, no pulse.
  - sync_q=1 and cnt<DEBOUNCE-1: increment cnt.
  - sync_q=1 and cnt==DEBOUNCE-1: go to STABLE_HI, set btn_level=1, pulse btn_rise.
REQ-014 STABLE_HI and WAIT_LO shall mirror REQ-012/013 with the polarity inverted; acceptance drives btn_level=0 and pulses btn_fall.
REQ-015 With en=0, the FSM, cnt and btn_level shall hold; a glitch in sync_q during en=0 shall have no effect.
REQ-016 btn_rise and btn_fall shall be high for exactly one clk cycle, in the cycle after the accepting edge, regardless of en width; they shall never be high together.
REQ-017 Latency with en tied to 1: btn_level shall change DEBOUNCE+2 rising edges after the first edge that samples the new btn_in value.
REQ-018 cnt width shall be $clog2(DEBOUNCE) bits; cnt shall never exceed DEBOUNCE-1 and shall never wrap.
REQ-019 An illegal state shall recover to STABLE_LO or STABLE_HI according to btn_level on the next edge, with no pulse.

Reset
REQ-020 When rst_n=0, asynchronously:
  - synchronizer flops = INIT_LEVEL;
  - state = STABLE_HI if INIT_LEVEL=1, else STABLE_LO;
  - cnt = 0, btn_level = INIT_LEVEL, btn_rise = 0, btn_fall = 0.
REQ-021 Reset asserted mid-WAIT shall abort the pending change with no pulse.
REQ-022 After rst_n deasserts, the first state update shall occur on the next qualified edge.

Structure
REQ-023 The state encodings (2-bit STABLE_LO=0, WAIT_HI=1, STABLE_HI=2, WAIT_LO=3) shall live in shared package debounce_pkg for reuse by downstream FSMs and benches.
REQ-024 The synchronizer shall be sub-module sync_2ff (clk, rst_n, d, q, reset value parameter); the FSM and counter stay in btn_debounce.
REQ-025 The block shall contain no combinational path from btn_in to any output.

Verification (DEBOUNCE=4, INIT_LEVEL=0, en=1 unless stated)
REQ-026 Clean press: btn_in 0->1 before edge 0, held -> btn_level=1 after edge 6; btn_rise high for the single cycle after edge 6.
REQ-027 Bounce: btn_in high 2 cycles, low 1 cycle, then high held -> no pulse from the first burst; btn_rise once, DEBOUNCE+2 edges after the final rise.
REQ-028 Release: from STABLE_HI, btn_in 1->0 held -> btn_level=0 after 6 edges; btn_fall one cycle; btn_rise stays 0.
REQ-029 Enable gating: en high every 3rd cycle, btn_in held high -> btn_level rises only after 4 qualified cycles in WAIT_HI; pulse width 1 clk.
REQ-030 Reset mid-operation: rst_n low while cnt=2 in WAIT_HI -> outputs 0 immediately, state STABLE_LO, no btn_rise after release.
REQ-031 INIT_LEVEL=1: after reset, btn_level=1 with btn_in held high -> no pulse for 20 cycles.

Source files
------------

// File: rtl/debounce_pkg.sv
// debounce_pkg
// Shared definitions for the button debouncer and anything downstream that
// needs to decode its state (other FSMs, benches).
//   deb_state_e   : 2-bit debouncer state encoding
//   stable_state(): settled state that corresponds to a given debounced level
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } deb_state_e;

  // Used for the reset state and for recovering from an unexpected encoding.
  function automatic deb_state_e stable_state(input logic level);
    return level ? STABLE_HI : STABLE_LO;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Two-flop synchronizer for a single asynchronous input bit.
// Ports:
//   clk   : sampling clock
//   rst_n : asynchronous active-low reset, both flops load RESET_VAL
//   d     : asynchronous input
//   q     : synchronized output, two clk edges behind d
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic stage1_q;
  logic stage2_q;

  // The first stage may go metastable; the second gives it a full cycle to
  // settle before anything downstream looks at it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1_q <= RESET_VAL;
      stage2_q <= RESET_VAL;
    end else begin
      stage1_q <= d;
      stage2_q <= stage1_q;
    end
  end

  assign q = stage2_q;

endmodule

// File: rtl/btn_debounce.sv
// btn_debounce
// Debounces a raw button/contact input. The input is synchronized every
// cycle, then a four-state FSM with a saturating-free counter accepts a level
// change only after DEBOUNCE consecutive enabled cycles of the new value.
// Ports:
//   clk       : single clock, all state on the rising edge
//   rst_n     : asynchronous active-low reset
//   en        : sample enable; FSM and counter advance only when high
//   btn_in    : raw asynchronous button input
//   btn_level : debounced level (registered)
//   btn_rise  : one-clk pulse on an accepted 0->1 change (registered)
//   btn_fall  : one-clk pulse on an accepted 1->0 change (registered)
// Parameters:
//   DEBOUNCE   : stable enabled cycles needed to accept a change (2..65535)
//   INIT_LEVEL : debounced level after reset
module btn_debounce
  import debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE   = 4,
  parameter logic        INIT_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall
);

  localparam int unsigned CW = $clog2(DEBOUNCE);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic       sync_q;
  deb_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic       level_q, level_d;
  logic       rise_q, rise_d;
  logic       fall_q, fall_d;

  sync_2ff #(
    .RESET_VAL(INIT_LEVEL)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (btn_in),
    .q    (sync_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= stable_state(INIT_LEVEL);
      cnt_q   <= '0;
      level_q <= INIT_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Pulses default low every cycle, so they last exactly one clk no matter
  // how long en stays high. The counter stops at CNT_MAX because reaching it
  // always leaves the WAIT state, so it can never wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    case (state_q)
      STABLE_LO: begin
        if (en && sync_q) begin
          state_d = WAIT_HI;
          cnt_d   = '0;
        end
      end

      WAIT_HI: begin
        if (en) begin
          if (!sync_q) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
            level_d = 1'b1;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      STABLE_HI: begin
        if (en && !sync_q) begin
          state_d = WAIT_LO;
          cnt_d   = '0;
        end
      end

      WAIT_LO: begin
        if (en) begin
          if (sync_q) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
            level_d = 1'b0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      // Unexpected encoding: fall back to the settled state matching the
      // current level, independent of en, without pulsing.
      default: begin
        state_d = stable_state(level_q);
        cnt_d   = '0;
      end
    endcase
  end

  assign btn_level = level_q;
  assign btn_rise  = rise_q;
  assign btn_fall  = fall_q;

endmodule
